// File: rtl/gpio_wb_arbiter.sv
`default_nettype none
// ============================================================================
// gpio_wb_arbiter : two-master round-robin Wishbone arbiter with response
//                   timeout in front of the GPIO slave port.
// Revision 1.0
// ============================================================================
`ifndef WB_AD_WIDTH
`define WB_AD_WIDTH 32
`endif
`ifndef WB_DAT_WIDTH
`define WB_DAT_WIDTH 32
`endif

module gpio_wb_arbiter #(
  parameter int          AW       = `WB_AD_WIDTH,
  parameter int          DW       = `WB_DAT_WIDTH,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_wdata_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  output logic [DW-1:0]   m0_rdata_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  input  logic [DW-1:0]   s_rdata_i,
  input  logic            s_ack_i,
  output logic [7:0]      timeout_cnt_o
);

  localparam int            SW      = DW / 8;
  localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_DW  = DW'(ERR_DATA);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          rr_last_q, rr_last_d;
  logic [15:0]   to_cnt_q, to_cnt_d;
  logic          s_cyc_q, s_cyc_d;
  logic          s_stb_q, s_stb_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic [SW-1:0] s_sel_q, s_sel_d;
  logic          s_we_q, s_we_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_err_q, m1_err_d;
  logic [7:0]    timeout_cnt_q, timeout_cnt_d;

  logic          m0_req, m1_req;
  logic          pick;
  logic          gnt_cyc;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_last_d     = rr_last_q;
    to_cnt_d      = to_cnt_q;
    s_cyc_d       = s_cyc_q;
    s_stb_d       = s_stb_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_sel_d       = s_sel_q;
    s_we_d        = s_we_q;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;
    m0_err_d      = 1'b0;
    m1_err_d      = 1'b0;
    timeout_cnt_d = timeout_cnt_q;
    pick          = 1'b0;
    gnt_cyc       = grant_q ? m1_cyc_i : m0_cyc_i;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that did not win last time goes first.
          pick      = (m0_req && m1_req) ? ~rr_last_q : m1_req;
          grant_d   = pick;
          rr_last_d = pick;
          s_cyc_d   = 1'b1;
          s_stb_d   = 1'b1;
          if (pick) begin
            s_addr_d  = m1_addr_i;
            s_wdata_d = m1_wdata_i;
            s_sel_d   = m1_sel_i;
            s_we_d    = m1_we_i;
          end else begin
            s_addr_d  = m0_addr_i;
            s_wdata_d = m0_wdata_i;
            s_sel_d   = m0_sel_i;
            s_we_d    = m0_we_i;
          end
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // An ack seen here may belong to the previous transfer, so ignore it.
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (!gnt_cyc) begin
          s_cyc_d   = 1'b0;
          s_stb_d   = 1'b0;
          s_addr_d  = '0;
          s_wdata_d = '0;
          s_sel_d   = '0;
          s_we_d    = 1'b0;
          state_d   = S_GAP;
        end else if (s_ack_i) begin
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          if (grant_q) begin
            m1_rdata_d = s_rdata_i;
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = s_rdata_i;
            m0_ack_d   = 1'b1;
          end
          state_d = S_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          s_cyc_d   = 1'b0;
          s_stb_d   = 1'b0;
          s_addr_d  = '0;
          s_wdata_d = '0;
          s_sel_d   = '0;
          s_we_d    = 1'b0;
          if (grant_q) begin
            m1_rdata_d = ERR_DW;
            m1_err_d   = 1'b1;
          end else begin
            m0_rdata_d = ERR_DW;
            m0_err_d   = 1'b1;
          end
          if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end

      S_DONE: state_d = S_GAP;

      S_GAP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      rr_last_q     <= 1'b1;
      to_cnt_q      <= '0;
      s_cyc_q       <= 1'b0;
      s_stb_q       <= 1'b0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      s_sel_q       <= '0;
      s_we_q        <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_err_q      <= 1'b0;
      m1_err_q      <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_last_q     <= rr_last_d;
      to_cnt_q      <= to_cnt_d;
      s_cyc_q       <= s_cyc_d;
      s_stb_q       <= s_stb_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_sel_q       <= s_sel_d;
      s_we_q        <= s_we_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
      m0_err_q      <= m0_err_d;
      m1_err_q      <= m1_err_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign s_cyc_o       = s_cyc_q;
  assign s_stb_o       = s_stb_q;
  assign s_addr_o      = s_addr_q;
  assign s_wdata_o     = s_wdata_q;
  assign s_sel_o       = s_sel_q;
  assign s_we_o        = s_we_q;
  assign m0_rdata_o    = m0_rdata_q;
  assign m1_rdata_o    = m1_rdata_q;
  assign m0_ack_o      = m0_ack_q;
  assign m1_ack_o      = m1_ack_q;
  assign m0_err_o      = m0_err_q;
  assign m1_err_o      = m1_err_q;
  assign timeout_cnt_o = timeout_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_gpio_wb_arbiter : directed + randomized transaction-level bench for
//                      gpio_wb_arbiter.
// Revision 1.0
// ============================================================================
module tb_gpio_wb_arbiter;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  logic [31:0] m_rdata[2];
  logic [3:0]  m_sel[2];
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic [7:0]  tcnt;

  int          n_assert = 0;
  int          n_fail   = 0;

  // Transaction-level reference state
  bit          rr_last = 1'b1;
  logic [31:0] exp_rdata[2];
  int          exp_tcnt = 0;

  always #5 clk = ~clk;

  gpio_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(ERRV)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_cyc_i     (m_cyc[0]),
    .m0_stb_i     (m_stb[0]),
    .m0_addr_i    (m_addr[0]),
    .m0_wdata_i   (m_wdata[0]),
    .m0_sel_i     (m_sel[0]),
    .m0_we_i      (m_we[0]),
    .m0_rdata_o   (m_rdata[0]),
    .m0_ack_o     (m_ack[0]),
    .m0_err_o     (m_err[0]),
    .m1_cyc_i     (m_cyc[1]),
    .m1_stb_i     (m_stb[1]),
    .m1_addr_i    (m_addr[1]),
    .m1_wdata_i   (m_wdata[1]),
    .m1_sel_i     (m_sel[1]),
    .m1_we_i      (m_we[1]),
    .m1_rdata_o   (m_rdata[1]),
    .m1_ack_o     (m_ack[1]),
    .m1_err_o     (m_err[1]),
    .s_cyc_o      (s_cyc),
    .s_stb_o      (s_stb),
    .s_addr_o     (s_addr),
    .s_wdata_o    (s_wdata),
    .s_sel_o      (s_sel),
    .s_we_o       (s_we),
    .s_rdata_i    (s_rdata),
    .s_ack_i      (s_ack),
    .timeout_cnt_o(tcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_cyc"},   32'(s_cyc),   0);
    chk({tag, "_s_stb"},   32'(s_stb),   0);
    chk({tag, "_s_addr"},  s_addr,       0);
    chk({tag, "_s_wdata"}, s_wdata,      0);
    chk({tag, "_s_sel"},   32'(s_sel),   0);
    chk({tag, "_s_we"},    32'(s_we),    0);
    chk({tag, "_ack"},     32'(m_ack),   0);
    chk({tag, "_err"},     32'(m_err),   0);
    chk({tag, "_rdata0"},  m_rdata[0],   0);
    chk({tag, "_rdata1"},  m_rdata[1],   0);
    chk({tag, "_tcnt"},    32'(tcnt),    0);
  endtask

  // One transfer starting in an IDLE cycle. w: WAIT cycle index at which the
  // slave acks; abort_at: WAIT cycle index at which the granted master drops
  // cyc (-1 = never); stale: s_ack held high throughout. Returns in IDLE.
  task automatic xfer(input logic [1:0] mask, input int w, input int abort_at,
                      input bit stale, input logic [31:0] rdv);
    int          g;
    int          i;
    int          outcome;
    logic [31:0] tmp;
    for (int m = 0; m < 2; m++) begin
      tmp       = $urandom;
      tmp[31]   = m[0];
      m_addr[m] = tmp;
      m_wdata[m] = $urandom;
      m_sel[m]  = 4'($urandom_range(1, 15));
      m_we[m]   = 1'($urandom_range(0, 1));
      m_cyc[m]  = mask[m];
      m_stb[m]  = mask[m];
    end
    s_rdata = rdv;
    s_ack   = stale;
    g = (mask == 2'b11) ? (rr_last ? 0 : 1) : (mask[1] ? 1 : 0);
    rr_last = (g == 1);
    tick();
    chk("req_cyc",   32'(s_cyc), 1);
    chk("req_stb",   32'(s_stb), 1);
    chk("req_addr",  s_addr,     m_addr[g]);
    chk("req_wdata", s_wdata,    m_wdata[g]);
    chk("req_sel",   32'(s_sel), 32'(m_sel[g]));
    chk("req_we",    32'(s_we),  32'(m_we[g]));
    tick();
    outcome = 0;
    i = 0;
    while (outcome == 0) begin
      chk("wait_stb",    32'(s_stb),          1);
      chk("wait_ackerr", 32'(m_ack | m_err),  0);
      s_ack = stale || (i == w);
      if (i == abort_at) begin
        m_cyc[g] = 1'b0;
        m_stb[g] = 1'b0;
        outcome = 1;
      end else if (s_ack) begin
        outcome = 2;
      end else if (i == TO - 1) begin
        outcome = 3;
      end
      i++;
      tick();
    end
    s_ack = stale;
    case (outcome)
      1: begin
        chk("abort_cyc",    32'(s_cyc),         0);
        chk("abort_ackerr", 32'(m_ack | m_err), 0);
        tick();
        chk("abort_idle_cyc", 32'(s_cyc),       0);
        chk("abort_idle_ack", 32'(m_ack | m_err), 0);
      end
      2: begin
        exp_rdata[g] = rdv;
        chk("done_ack_g",   32'(m_ack[g]),   1);
        chk("done_ack_o",   32'(m_ack[1-g]), 0);
        chk("done_err",     32'(m_err),      0);
        chk("done_rdata_g", m_rdata[g],      exp_rdata[g]);
        chk("done_rdata_o", m_rdata[1-g],    exp_rdata[1-g]);
        chk("done_cyc",     32'(s_cyc),      0);
        m_cyc[g] = 1'b0;
        m_stb[g] = 1'b0;
        tick();
        chk("gap_ackerr", 32'(m_ack | m_err), 0);
        chk("gap_cyc",    32'(s_cyc),         0);
        tick();
      end
      default: begin
        exp_rdata[g] = ERRV;
        exp_tcnt = (exp_tcnt < 255) ? exp_tcnt + 1 : 255;
        chk("to_err_g",   32'(m_err[g]),   1);
        chk("to_err_o",   32'(m_err[1-g]), 0);
        chk("to_ack",     32'(m_ack),      0);
        chk("to_rdata_g", m_rdata[g],      exp_rdata[g]);
        chk("to_rdata_o", m_rdata[1-g],    exp_rdata[1-g]);
        chk("to_tcnt",    32'(tcnt),       32'(exp_tcnt));
        chk("to_cyc",     32'(s_cyc),      0);
        m_cyc[g] = 1'b0;
        m_stb[g] = 1'b0;
        tick();
        chk("to_gap_ackerr", 32'(m_ack | m_err), 0);
        tick();
      end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, ab;
    bit st;
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_wdata[m] = '0; m_sel[m] = '0; exp_rdata[m] = '0;
    end
    s_ack = 1'b0; s_rdata = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single read from master 0 acked on the second WAIT cycle
    xfer(2'b01, 1, -1, 1'b0, 32'h0000_00A5);
    chk("single_rdata", m_rdata[0], 32'h0000_00A5);

    // Stale ack held high across two transfers
    xfer(2'b10, 99, -1, 1'b1, $urandom);
    xfer(2'b01, 99, -1, 1'b1, $urandom);

    // Contention: alternating grants
    for (int k = 0; k < 6; k++) xfer(2'b11, int'($urandom_range(0, 3)), -1, 1'b0, $urandom);

    // Timeout on master 1
    xfer(2'b10, 1000, -1, 1'b0, $urandom);
    chk("timeout_rdata", m_rdata[1], ERRV);
    chk("timeout_cnt1",  32'(tcnt),  1);

    // Ack coinciding with the last timeout cycle completes normally
    xfer(2'b01, TO - 1, -1, 1'b0, $urandom);

    // Abort by master 0 with master 1 pending, then m1 served
    xfer(2'b10, 0, -1, 1'b0, $urandom);
    xfer(2'b11, 5, 1, 1'b0, $urandom);
    xfer(2'b10, 0, -1, 1'b0, $urandom);
    // Abort and ack in the same cycle: abort wins
    xfer(2'b01, 0, 0, 1'b0, $urandom);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      w  = int'($urandom_range(0, TO + 1));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
      st = ($urandom_range(0, 5) == 0);
      xfer(2'($urandom_range(1, 3)), w, ab, st, $urandom);
    end

    // Counter saturation
    for (int k = 0; k < 300; k++) xfer(2'($urandom_range(1, 3)), 1000, -1, 1'b0, $urandom);
    chk("tcnt_saturated", 32'(tcnt), 255);

    // Reset in the middle of an m0 WAIT
    s_ack = 1'b0;
    m_cyc = 2'b01; m_stb = 2'b01;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    m_cyc = '0; m_stb = '0;
    rr_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0; exp_tcnt = 0;
    tick();
    xfer(2'b11, 0, -1, 1'b0, $urandom);
    chk("post_rst_grant_m0", 32'(m_rdata[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
